// File: rtl/apb_event_sink_if.sv
// -----------------------------------------------------------------------------
// apb_event_sink_if
// Purpose : APB bus bundle between the upstream event master and the
//           apb_event_sink completer. Signal names keep the completer's
//           _i/_o direction suffixes so they read the same at both ends.
// Signals :
//   apb_psel_i     master -> sink  select
//   apb_penable_i  master -> sink  access phase
//   apb_paddr_i    master -> sink  32-bit address
//   apb_pwrite_i   master -> sink  write strobe
//   apb_pwdata_i   master -> sink  write data (pending count)
//   apb_pready_o   sink -> master  transfer complete
//   apb_pslverr_o  sink -> master  transfer error
// -----------------------------------------------------------------------------
interface apb_event_sink_if;
  logic        apb_psel_i;
  logic        apb_penable_i;
  logic [31:0] apb_paddr_i;
  logic        apb_pwrite_i;
  logic [31:0] apb_pwdata_i;
  logic        apb_pready_o;
  logic        apb_pslverr_o;

  modport master (
    output apb_psel_i, apb_penable_i, apb_paddr_i, apb_pwrite_i, apb_pwdata_i,
    input  apb_pready_o, apb_pslverr_o
  );

  modport slave (
    input  apb_psel_i, apb_penable_i, apb_paddr_i, apb_pwrite_i, apb_pwdata_i,
    output apb_pready_o, apb_pslverr_o
  );
endinterface

// File: rtl/apb_event_sink.sv
// -----------------------------------------------------------------------------
// apb_event_sink
// Purpose : APB completer terminating the event write stream. Decodes three
//           event addresses, keeps a saturating count per event, logs each
//           accepted event write into a first-word-fall-through FIFO that a
//           valid/ready consumer drains, inserts WAIT_CYCLES wait states and
//           holds apb_pready_o low while a mapped write finds the FIFO full.
// Option  : define APB_SINK_PSLVERR_EN to flag writes to unmapped addresses
//           with apb_pslverr_o; otherwise such writes are silently dropped.
// Ports   :
//   clk, reset                  clock, synchronous active-high reset
//   apb (slave modport)         APB completer side
//   cnt_a_o/cnt_b_o/cnt_c_o     accepted writes to ABBA_0000/BAFF_0000/CAFE_0000
//   log_valid_o, log_ready_i    FIFO head handshake
//   log_id_o, log_data_o        head event id (0=A,1=B,2=C) and pwdata
//   log_level_o                 FIFO occupancy
// -----------------------------------------------------------------------------
module apb_event_sink #(
  parameter int WAIT_CYCLES = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  apb_event_sink_if.slave   apb,
  output logic [CNT_W-1:0]  cnt_a_o,
  output logic [CNT_W-1:0]  cnt_b_o,
  output logic [CNT_W-1:0]  cnt_c_o,
  output logic              log_valid_o,
  input  logic              log_ready_i,
  output logic [1:0]        log_id_o,
  output logic [31:0]       log_data_o,
  output logic [4:0]        log_level_o
);

  localparam int          PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ADDR_A = 32'hABBA_0000;
  localparam logic [31:0] ADDR_B = 32'hBAFF_0000;
  localparam logic [31:0] ADDR_C = 32'hCAFE_0000;

  // r_state holds the bus phase sampled at the previous edge: SETUP means the
  // current cycle is the first access cycle, ACCESS means a stalled access
  // continues. Knowing this from a register lets pready rise in the very first
  // access cycle when no wait states are configured.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           r_state;
  logic [3:0]       r_waitCnt;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [4:0]       r_level;
  logic [1:0]       r_memId   [FIFO_DEPTH];
  logic [31:0]      r_memData [FIFO_DEPTH];
  logic [CNT_W-1:0] r_cntA;
  logic [CNT_W-1:0] r_cntB;
  logic [CNT_W-1:0] r_cntC;

  logic       w_mapped;
  logic [1:0] w_id;
  logic       w_full;
  logic       w_slotFree;
  logic       w_inAccess;
  logic       w_ready;
  logic       w_push;
  logic       w_pop;

  // Exact 32-bit decode of the three event addresses; anything else is unmapped.
  always_comb begin
    w_mapped = 1'b1;
    w_id     = 2'd0;
    case (apb.apb_paddr_i)
      ADDR_A:  w_id = 2'd0;
      ADDR_B:  w_id = 2'd1;
      ADDR_C:  w_id = 2'd2;
      default: w_mapped = 1'b0;
    endcase
  end

  // Only a mapped write needs a FIFO slot; reads and unmapped writes never stall.
  // Full is taken from the registered level, so a pop on the same edge does not
  // free the slot until the following cycle.
  assign w_full     = (r_level == 5'(FIFO_DEPTH));
  assign w_slotFree = !w_full || !apb.apb_pwrite_i || !w_mapped;
  assign w_inAccess = (r_state != IDLE) && apb.apb_psel_i && apb.apb_penable_i;
  assign w_ready    = w_inAccess && (r_waitCnt == 4'(WAIT_CYCLES)) && w_slotFree;
  assign w_push     = w_ready && apb.apb_pwrite_i && w_mapped;
  assign w_pop      = (r_level != 5'd0) && log_ready_i;

  assign apb.apb_pready_o = w_ready;

`ifdef APB_SINK_PSLVERR_EN
  assign apb.apb_pslverr_o = w_ready && apb.apb_pwrite_i && !w_mapped;
`else
  assign apb.apb_pslverr_o = 1'b0;
`endif

  // Phase tracker and wait-state counter. A setup phase arms the access and
  // clears the counter; each stalled access cycle bumps the counter up to
  // WAIT_CYCLES. Completion, a dropped psel or penable without a preceding setup
  // all fall back to IDLE, so a protocol violation never produces a completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
    end else if (apb.apb_psel_i && !apb.apb_penable_i) begin
      r_state   <= SETUP;
      r_waitCnt <= '0;
    end else if (w_inAccess && !w_ready) begin
      r_state <= ACCESS;
      if (r_waitCnt < 4'(WAIT_CYCLES)) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
    end else begin
      r_state <= IDLE;
    end
  end

  // Event log FIFO. Storage is cleared on reset so the head outputs read zero
  // while empty. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_memId[i]   <= '0;
        r_memData[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_memId[r_wrPtr]   <= w_id;
        r_memData[r_wrPtr] <= apb.apb_pwdata_i;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Per-event counters move only with an actual push and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cntA <= '0;
      r_cntB <= '0;
      r_cntC <= '0;
    end else if (w_push) begin
      case (w_id)
        2'd0:    if (r_cntA != '1) r_cntA <= r_cntA + 1'b1;
        2'd1:    if (r_cntB != '1) r_cntB <= r_cntB + 1'b1;
        default: if (r_cntC != '1) r_cntC <= r_cntC + 1'b1;
      endcase
    end
  end

  assign cnt_a_o     = r_cntA;
  assign cnt_b_o     = r_cntB;
  assign cnt_c_o     = r_cntC;
  assign log_valid_o = (r_level != 5'd0);
  assign log_id_o    = r_memId[r_rdPtr];
  assign log_data_o  = r_memData[r_rdPtr];
  assign log_level_o = r_level;

endmodule

// File: tb/tb_apb_event_sink.sv
// -----------------------------------------------------------------------------
// tb_apb_event_sink
// Purpose : self-checking bench for apb_event_sink. A queue-based model of the
//           event log and plain integer counters predict every output each
//           cycle; directed sequences, a vector table and a randomized run
//           drive the APB side. Counters use CNT_W=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_apb_event_sink;

  localparam int          WAIT_CYCLES = 1;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;
  localparam logic [31:0] ADDR_A      = 32'hABBA_0000;
  localparam logic [31:0] ADDR_B      = 32'hBAFF_0000;
  localparam logic [31:0] ADDR_C      = 32'hCAFE_0000;
`ifdef APB_SINK_PSLVERR_EN
  localparam bit          ERR_EN      = 1'b1;
`else
  localparam bit          ERR_EN      = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             logReady;
  logic [CNT_W-1:0] cntA, cntB, cntC;
  logic             logValid;
  logic [1:0]       logId;
  logic [31:0]      logData;
  logic [4:0]       logLevel;

  apb_event_sink_if apb ();

  apb_event_sink #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .apb        (apb),
    .cnt_a_o    (cntA),
    .cnt_b_o    (cntB),
    .cnt_c_o    (cntC),
    .log_valid_o(logValid),
    .log_ready_i(logReady),
    .log_id_o   (logId),
    .log_data_o (logData),
    .log_level_o(logLevel)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: the log is a queue of {id, data}, counters are plain ints.
  // mArmed says the bus is inside a transfer whose setup phase was seen;
  // mWait counts access cycles already spent on that transfer.
  logic [33:0] mQ[$];
  int          mCnt[3];
  int          mWait;
  bit          mArmed;
  bit          lastReady, lastErr, lastActReady, lastActErr;
  bit          randReady;

  // Single comparison point: every check steps nChecks and, on success, nPass.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int idOf(input logic [31:0] addr);
    if (addr == ADDR_A) return 0;
    if (addr == ADDR_B) return 1;
    if (addr == ADDR_C) return 2;
    return -1;
  endfunction

  // One clock cycle: check outputs at the falling edge against the model, then
  // advance the model by what must happen at the following rising edge.
  task automatic cycle();
    int id;
    bit write, mapped, inAccess, slotFree, expReady, expErr, pop, push;
    if (randReady) logReady = 1'($urandom_range(0, 1));
    @(negedge clk);
    id       = idOf(apb.apb_paddr_i);
    mapped   = (id >= 0);
    write    = apb.apb_pwrite_i;
    inAccess = mArmed && apb.apb_psel_i && apb.apb_penable_i;
    slotFree = !write || !mapped || (mQ.size() < FIFO_DEPTH);
    expReady = inAccess && (mWait >= WAIT_CYCLES) && slotFree;
    expErr   = ERR_EN && expReady && write && !mapped;
    checkOutput("pready", apb.apb_pready_o, expReady);
    checkOutput("pslverr", apb.apb_pslverr_o, expErr);
    checkOutput("log_valid", logValid, mQ.size() != 0);
    checkOutput("log_level", logLevel, mQ.size());
    if (mQ.size() != 0) begin
      checkOutput("log_id", logId, mQ[0][33:32]);
      checkOutput("log_data", logData, mQ[0][31:0]);
    end
    checkOutput("cnt_a", cntA, mCnt[0]);
    checkOutput("cnt_b", cntB, mCnt[1]);
    checkOutput("cnt_c", cntC, mCnt[2]);
    lastReady    = expReady;
    lastErr      = expErr;
    lastActReady = apb.apb_pready_o;
    lastActErr   = apb.apb_pslverr_o;
    if (reset) begin
      mQ.delete();
      mCnt   = '{0, 0, 0};
      mWait  = 0;
      mArmed = 0;
    end else begin
      pop  = (mQ.size() != 0) && logReady;
      push = expReady && write && mapped;
      if (pop) void'(mQ.pop_front());
      if (push) begin
        mQ.push_back({id[1:0], apb.apb_pwdata_i});
        if (mCnt[id] < CNT_MAX) mCnt[id]++;
      end
      if (apb.apb_psel_i && !apb.apb_penable_i) begin
        mArmed = 1;
        mWait  = 0;
      end else if (inAccess && !expReady) begin
        mArmed = 1;
        mWait++;
      end else begin
        mArmed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Full APB transfer: one setup cycle, then access cycles until completion.
  // keepSel leaves psel high so the next call forms a back-to-back transfer.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input bit write,
                               input bit keepSel, output int nAccess, output bit actErr);
    bit done;
    apb.apb_psel_i    = 1'b1;
    apb.apb_penable_i = 1'b0;
    apb.apb_paddr_i   = addr;
    apb.apb_pwdata_i  = data;
    apb.apb_pwrite_i  = write;
    cycle();
    apb.apb_penable_i = 1'b1;
    done    = 0;
    nAccess = 0;
    actErr  = 0;
    while (!done && nAccess < 40) begin
      cycle();
      nAccess++;
      done   = lastReady;
      actErr = lastActErr;
    end
    if (!done) begin
      nChecks++;
      $display("[TB] FAIL timeout: no completion for addr 0x%0h after %0d access cycles", addr, nAccess);
    end
    apb.apb_penable_i = 1'b0;
    if (!keepSel) apb.apb_psel_i = 1'b0;
  endtask

  task automatic drain();
    logReady = 1'b1;
    repeat (FIFO_DEPTH + 1) cycle();
    logReady = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          write;
    int          expLogged;
    bit          expErr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  nAcc;
    bit  err;
    int  pick;
    logic [31:0] addr;

    vecs[0] = '{ADDR_A,        32'h0000_0101, 1'b1, 1, 1'b0};
    vecs[1] = '{32'h1234_0000, 32'h0000_0202, 1'b1, 0, ERR_EN};
    vecs[2] = '{32'hABBA_0001, 32'h0000_0303, 1'b1, 0, ERR_EN};
    vecs[3] = '{ADDR_C,        32'h0000_0404, 1'b0, 0, 1'b0};
    vecs[4] = '{32'h1234_0000, 32'h0000_0505, 1'b0, 0, 1'b0};
    vecs[5] = '{ADDR_B,        32'h0000_0606, 1'b1, 1, 1'b0};
    vecs[6] = '{ADDR_C,        32'hDEAD_BEEF, 1'b1, 1, 1'b0};

    mCnt      = '{0, 0, 0};
    mWait     = 0;
    mArmed    = 0;
    randReady = 0;
    reset     = 1'b1;
    logReady  = 1'b0;
    apb.apb_psel_i    = 1'b0;
    apb.apb_penable_i = 1'b0;
    apb.apb_paddr_i   = '0;
    apb.apb_pwrite_i  = 1'b0;
    apb.apb_pwdata_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset pready", apb.apb_pready_o, 0);
    checkOutput("reset log_valid", logValid, 0);
    checkOutput("reset log_id", logId, 0);
    checkOutput("reset log_data", logData, 0);
    checkOutput("reset level", logLevel, 0);
    checkOutput("reset cnt_a", cntA, 0);
    reset = 1'b0;
    cycle();

    // 1: single write, completion lands in the second access cycle.
    $display("[TB] single write");
    applyStimulus(ADDR_A, 32'd5, 1'b1, 1'b0, nAcc, err);
    checkOutput("t1 access cycles", nAcc, WAIT_CYCLES + 1);
    checkOutput("t1 cnt_a", cntA, 1);
    checkOutput("t1 log_valid", logValid, 1);
    checkOutput("t1 log_id", logId, 0);
    checkOutput("t1 log_data", logData, 5);
    checkOutput("t1 level", logLevel, 1);
    drain();

    // 2: back-to-back A, B, C with the consumer always ready.
    $display("[TB] back-to-back");
    logReady = 1'b1;
    applyStimulus(ADDR_A, 32'd11, 1'b1, 1'b1, nAcc, err);
    applyStimulus(ADDR_B, 32'd22, 1'b1, 1'b1, nAcc, err);
    applyStimulus(ADDR_C, 32'd33, 1'b1, 1'b0, nAcc, err);
    cycle();
    checkOutput("t2 level", logLevel, 0);
    checkOutput("t2 cnt_a", cntA, 2);
    checkOutput("t2 cnt_b", cntB, 1);
    checkOutput("t2 cnt_c", cntC, 1);
    logReady = 1'b0;

    // 3: fill the FIFO, stall the fifth write, release it with one pop.
    $display("[TB] full back-pressure");
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(ADDR_C, 32'(100 + i), 1'b1, 1'b0, nAcc, err);
    apb.apb_psel_i    = 1'b1;
    apb.apb_penable_i = 1'b0;
    apb.apb_paddr_i   = ADDR_C;
    apb.apb_pwdata_i  = 32'd104;
    apb.apb_pwrite_i  = 1'b1;
    cycle();
    apb.apb_penable_i = 1'b1;
    repeat (3) begin
      cycle();
      checkOutput("t3 stalled pready", lastActReady, 0);
    end
    logReady = 1'b1;
    cycle();
    checkOutput("t3 pop-cycle pready", lastActReady, 0);
    logReady = 1'b0;
    cycle();
    checkOutput("t3 release pready", lastActReady, 1);
    apb.apb_psel_i    = 1'b0;
    apb.apb_penable_i = 1'b0;
    checkOutput("t3 cnt_c", cntC, 6);
    checkOutput("t3 level", logLevel, 4);
    checkOutput("t3 head data", logData, 101);
    drain();

    // 4: drive cnt_b to all-ones, then one more write must stick but still log.
    $display("[TB] counter saturation");
    logReady = 1'b1;
    for (int i = 0; i < CNT_MAX - 1; i++) applyStimulus(ADDR_B, 32'(i), 1'b1, 1'b0, nAcc, err);
    cycle();
    logReady = 1'b0;
    checkOutput("t4 cnt_b at max", cntB, CNT_MAX);
    applyStimulus(ADDR_B, 32'h0000_0BBB, 1'b1, 1'b0, nAcc, err);
    checkOutput("t4 cnt_b saturated", cntB, CNT_MAX);
    checkOutput("t4 level", logLevel, 1);
    checkOutput("t4 log_data", logData, 32'h0000_0BBB);
    drain();

    // 5: vector table of decode cases, including unmapped writes and reads.
    $display("[TB] decode table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].write, 1'b0, nAcc, err);
      checkOutput($sformatf("vec%0d pslverr", i), err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d logged", i), logLevel, vecs[i].expLogged);
      drain();
    end

    // psel dropped in the middle of an access: nothing may happen.
    $display("[TB] psel drop");
    apb.apb_psel_i    = 1'b1;
    apb.apb_penable_i = 1'b0;
    apb.apb_paddr_i   = ADDR_A;
    apb.apb_pwrite_i  = 1'b1;
    cycle();
    apb.apb_penable_i = 1'b1;
    cycle();
    apb.apb_psel_i    = 1'b0;
    apb.apb_penable_i = 1'b0;
    repeat (2) cycle();
    checkOutput("drop level", logLevel, 0);

    // 6: reset during an access with two entries queued.
    $display("[TB] reset mid-transfer");
    applyStimulus(ADDR_A, 32'd1, 1'b1, 1'b0, nAcc, err);
    applyStimulus(ADDR_B, 32'd2, 1'b1, 1'b0, nAcc, err);
    checkOutput("t6 level before", logLevel, 2);
    apb.apb_psel_i    = 1'b1;
    apb.apb_penable_i = 1'b0;
    apb.apb_paddr_i   = ADDR_C;
    apb.apb_pwdata_i  = 32'd3;
    cycle();
    apb.apb_penable_i = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    checkOutput("t6 pready after reset", lastActReady, 0);
    checkOutput("t6 level", logLevel, 0);
    checkOutput("t6 cnt_a", cntA, 0);
    checkOutput("t6 cnt_c", cntC, 0);
    apb.apb_psel_i    = 1'b0;
    apb.apb_penable_i = 1'b0;
    cycle();
    applyStimulus(ADDR_A, 32'h77, 1'b1, 1'b0, nAcc, err);
    checkOutput("t6 fresh cnt_a", cntA, 1);
    checkOutput("t6 fresh log_data", logData, 32'h77);

    // Randomized traffic with a random consumer, checked every cycle by the model.
    $display("[TB] random traffic");
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0:       addr = ADDR_A;
        1:       addr = ADDR_B;
        2, 3:    addr = ADDR_C;
        4:       addr = ADDR_A ^ (32'd1 << $urandom_range(0, 31));
        default: addr = $urandom;
      endcase
      applyStimulus(addr, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, nAcc, err);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    apb.apb_psel_i = 1'b0;
    randReady = 0;
    drain();
    checkOutput("final level", logLevel, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/apb_event_sink.md
Name: apb_event_sink

Overview:
APB completer that terminates the event write stream produced by the upstream APB event master.
- Decodes the three event addresses and keeps a per-event saturating count.
- Logs every accepted event write (event id plus the pending-count payload) into a small FIFO, drained by a downstream valid/ready consumer.
- Inserts programmable wait states and back-pressures the APB master with apb_pready_o while the FIFO is full.

Parameters:
WAIT_CYCLES, 1, wait states inserted in every access phase before apb_pready_o may assert (0..15)
FIFO_DEPTH, 4, event log entries; power of two, 2..16
CNT_W, 16, width of each per-event counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
apb_psel_i  input  1  APB select
apb_penable_i  input  1  APB enable (access phase)
apb_paddr_i  input  32  APB address
apb_pwrite_i  input  1  APB write strobe
apb_pwdata_i  input  32  APB write data (pending count from master)
apb_pready_o  output  1  transfer-complete strobe
apb_pslverr_o  output  1  transfer error (see Optional Feature)
cnt_a_o  output  CNT_W  accepted writes to 0xABBA_0000
cnt_b_o  output  CNT_W  accepted writes to 0xBAFF_0000
cnt_c_o  output  CNT_W  accepted writes to 0xCAFE_0000
log_valid_o  output  1  FIFO head valid
log_ready_i  input  1  consumer pops head when log_valid_o & log_ready_i
log_id_o  output  2  head event id: 0=A, 1=B, 2=C
log_data_o  output  32  head pwdata
log_level_o  output  5  current FIFO occupancy (0..FIFO_DEPTH)

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO empty, wait counter 0, counters 0. Reset asserted mid-transfer aborts it; no push, no count.
- States:
  - IDLE: no psel.
  - SETUP: psel & !penable, lasts one cycle.
  - ACCESS: psel & penable.
  - Transitions: IDLE->SETUP on psel; SETUP->ACCESS unconditionally; ACCESS->IDLE on completion, or ->SETUP if psel is held for a back-to-back transfer.
- Wait counter: cleared in SETUP; increments each ACCESS cycle while below WAIT_CYCLES.
- apb_pready_o: combinational from registered state, high only in ACCESS when wait counter == WAIT_CYCLES and the slot is free.
  - Slot free = FIFO not full, or the transfer is a read, or the address is unmapped.
  - With WAIT_CYCLES=0, pready is high in the first ACCESS cycle, giving a 2-cycle transfer.
- Completion: rising edge where psel & penable & pready.
- Decode on completion:
  - Exact 32-bit match against 0xABBA_0000 / 0xBAFF_0000 / 0xCAFE_0000.
  - Mapped write: push {id, pwdata} and increment the matching counter.
  - Counters saturate at all-ones; no wrap.
- Reads (pwrite=0): complete after the wait states with no side effects; read data is not supported.
- FIFO is first-word-fall-through:
  - log_valid_o = level != 0.
  - Push and pop in the same edge leave the level unchanged.
  - Full blocks a new push even if a pop occurs on the same edge; pready stays low until level < FIFO_DEPTH is registered.
  - Pointers wrap modulo FIFO_DEPTH.
  - log_id_o/log_data_o hold stable while valid and not popped.
- Address/data sampled only at completion; changes in earlier ACCESS cycles are ignored.
- psel dropped mid-ACCESS (protocol violation): return to IDLE, no side effects.

Optional Feature:
APB_SINK_PSLVERR_EN
- Defined: a write completing to an unmapped address asserts apb_pslverr_o together with apb_pready_o for that single cycle; nothing is logged or counted. Reads never error.
- Undefined: apb_pslverr_o tied 0; unmapped writes complete normally and are silently dropped.

Test Plan:
1. Reset, WAIT_CYCLES=1; write 0xABBA_0000 data 5 -> pready in 2nd ACCESS cycle; cnt_a_o=1; log_valid_o=1, log_id_o=0, log_data_o=5, log_level_o=1.
2. Writes A, B, C back-to-back with log_ready_i=1 -> pops in order ids 0,1,2; each counter =1; level returns to 0.
3. log_ready_i=0, FIFO_DEPTH=4; five writes to 0xCAFE_0000 -> 4 complete, 5th ACCESS holds pready=0; pulse log_ready_i one cycle -> 5th completes the following cycle; cnt_c_o=5, level=4.
4. Preload cnt_b_o to 0xFFFF via 65535 writes (or force); write B again -> cnt_b_o stays 0xFFFF and entry still logged.
5. Write 0x1234_0000 -> with APB_SINK_PSLVERR_EN: pslverr=1 with pready, no log/count; without: pslverr=0, no log/count.
6. Assert reset during ACCESS with level=2 -> next cycle pready=0, level=0, all counters 0; a fresh write afterwards completes normally.
